// File: rtl/io_check_pkg.sv
// Shared types for the IO sequence checker: FSM states, step-table entry layout, match rule.
// Purely declarative; no latency, no flow control.
package io_check_pkg;

    localparam int ENTRY_W        = 37;
    localparam int VALUE_LSB      = 0;
    localparam int MASK_LSB       = 16;
    localparam int STATUS_VAL_LSB = 32;
    localparam int STATUS_EN_BIT  = 36;
    localparam int IN_W           = 20;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } state_t;

    typedef struct packed {
        logic        status_en;
        logic [3:0]  status_val;
        logic [15:0] mask;
        logic [15:0] value;
    } entry_t;

    // Masked compare on the observed word; the status nibble only matters when enabled.
    function automatic logic step_match(input entry_t e, input logic [15:0] cb, input logic [3:0] st);
        return (((cb ^ e.value) & e.mask) == 16'h0) && (!e.status_en || (st == e.status_val));
    endfunction

endpackage

// File: rtl/io_sequence_checker_if.sv
// Config, pad-observation and status bundle of the IO sequence checker.
// Wires only; the checker never backpressures, start is a fire-and-forget pulse.
interface io_sequence_checker_if #(
    parameter int DEPTH = 8,
    parameter int TMO_W = 24
);
    import io_check_pkg::*;

    localparam int AW = $clog2(DEPTH);

    logic [15:0]        checkbits;
    logic [3:0]         status;
    logic               cfg_we;
    logic [AW-1:0]      cfg_addr;
    logic [ENTRY_W-1:0] cfg_data;
    logic [AW:0]        num_steps;
    logic [TMO_W-1:0]   tmo_limit;
    logic               start;
    logic               busy;
    logic               done;
    logic               pass;
    logic [AW-1:0]      fail_step;
    logic [AW-1:0]      cur_step;

    modport master (
        output checkbits, status, cfg_we, cfg_addr, cfg_data, num_steps, tmo_limit, start,
        input  busy, done, pass, fail_step, cur_step
    );

    modport slave (
        input  checkbits, status, cfg_we, cfg_addr, cfg_data, num_steps, tmo_limit, start,
        output busy, done, pass, fail_step, cur_step
    );

endinterface

// File: rtl/io_sync2.sv
// Two-flop synchronizer for asynchronous pad-side inputs; 2-cycle latency.
// No flow control; each bit is synchronized independently.
module io_sync2 #(
    parameter int W = 1
) (
    input  logic         clock,
    input  logic         resetb,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/io_sequence_checker.sv
// Steps through a programmed table of expected pad patterns, each held STABLE cycles, with per-step timeout.
// 2-cycle input sync + STABLE cycles per step; start is ignored while busy, no other backpressure.
module io_sequence_checker
    import io_check_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int TMO_W  = 24,
    parameter int STABLE = 2
) (
    input  logic                  clock,
    input  logic                  resetb,
    io_sequence_checker_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = 4;
    localparam logic [AW:0]   DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [SW-1:0] STABLE_C = SW'(STABLE);

    state_t           state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [SW-1:0]    stab_q, stab_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [AW:0]      nsteps_q, nsteps_d;
    logic [TMO_W-1:0] tlim_q, tlim_d;
    logic [AW-1:0]    fstep_q, fstep_d;

    logic [IN_W-1:0]  sync_in, sync_out;
    logic [15:0]      sync_cb;
    logic [3:0]       sync_st;
    entry_t           tbl [DEPTH];
    entry_t           cfg_entry;
    logic             match;
    logic [SW-1:0]    stab_inc;
    logic [TMO_W-1:0] tmo_inc;
    logic             last;

    assign sync_in = {bus.status, bus.checkbits};

    io_sync2 #(.W(IN_W)) u_sync (
        .clock  (clock),
        .resetb (resetb),
        .d      (sync_in),
        .q      (sync_out)
    );

    assign sync_cb = sync_out[15:0];
    assign sync_st = sync_out[19:16];

    assign cfg_entry.status_en  = bus.cfg_data[STATUS_EN_BIT];
    assign cfg_entry.status_val = bus.cfg_data[STATUS_VAL_LSB +: 4];
    assign cfg_entry.mask       = bus.cfg_data[MASK_LSB +: 16];
    assign cfg_entry.value      = bus.cfg_data[VALUE_LSB +: 16];

    // Writable at any time; a rewritten entry is seen the next time its step is evaluated.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
        end else if (bus.cfg_we) begin
            tbl[bus.cfg_addr] <= cfg_entry;
        end
    end

    assign match    = step_match(tbl[idx_q], sync_cb, sync_st);
    assign stab_inc = stab_q + 1'b1;
    assign tmo_inc  = tmo_q + 1'b1;
    assign last     = ({1'b0, idx_q} == (nsteps_q - 1'b1));

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            stab_q   <= '0;
            tmo_q    <= '0;
            nsteps_q <= '0;
            tlim_q   <= '0;
            fstep_q  <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            stab_q   <= stab_d;
            tmo_q    <= tmo_d;
            nsteps_q <= nsteps_d;
            tlim_q   <= tlim_d;
            fstep_q  <= fstep_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        stab_d   = stab_q;
        tmo_d    = tmo_q;
        nsteps_d = nsteps_q;
        tlim_d   = tlim_q;
        fstep_d  = fstep_q;
        case (state_q)
            ST_RUN: begin
                // Accept is checked first so it wins over a coincident timeout.
                if (match && (stab_inc >= STABLE_C)) begin
                    stab_d = '0;
                    tmo_d  = '0;
                    if (last) state_d = ST_PASS;
                    else      idx_d   = idx_q + 1'b1;
                end else begin
                    stab_d = match ? stab_inc : '0;
                    tmo_d  = tmo_inc;
                    if ((tlim_q != '0) && (tmo_inc >= tlim_q)) begin
                        state_d = ST_FAIL;
                        fstep_d = idx_q;
                    end
                end
            end
            default: begin
                if (bus.start) begin
                    nsteps_d = (bus.num_steps > DEPTH_C) ? DEPTH_C : bus.num_steps;
                    tlim_d   = bus.tmo_limit;
                    idx_d    = '0;
                    stab_d   = '0;
                    tmo_d    = '0;
                    fstep_d  = '0;
                    state_d  = (bus.num_steps == '0) ? ST_PASS : ST_RUN;
                end
            end
        endcase
    end

    assign bus.busy      = (state_q == ST_RUN);
    assign bus.done      = (state_q == ST_PASS) || (state_q == ST_FAIL);
    assign bus.pass      = (state_q == ST_PASS);
    assign bus.fail_step = fstep_q;
    assign bus.cur_step  = idx_q;

endmodule

// File: tb/tb_io_sequence_checker.sv
// Scenario bench for io_sequence_checker: expected run outcomes are queued at launch and checked at done.
module tb_io_sequence_checker;
    import io_check_pkg::*;

    localparam int DEPTH = 8;
    localparam int TMO_W = 24;

    logic clock = 1'b0;
    logic resetb;
    int   vectors = 0;
    int   miscompares = 0;

    typedef struct {
        logic       pass;
        logic [2:0] fstep;
    } exp_t;
    exp_t sb[$];

    always #5 clock = ~clock;

    io_sequence_checker_if #(.DEPTH(DEPTH), .TMO_W(TMO_W)) bus ();

    io_sequence_checker #(.DEPTH(DEPTH), .TMO_W(TMO_W), .STABLE(2)) dut (
        .clock  (clock),
        .resetb (resetb),
        .bus    (bus)
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic drive(input logic [15:0] cb, input logic [3:0] st);
        bus.checkbits = cb;
        bus.status    = st;
    endtask

    task automatic write_entry(input logic [2:0] a, input logic en, input logic [3:0] sv,
                               input logic [15:0] m, input logic [15:0] v);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = a;
        bus.cfg_data = {en, sv, m, v};
        tick();
        bus.cfg_we   = 1'b0;
    endtask

    task automatic load_main_table();
        write_entry(3'd0, 1'b0, 4'h0, 16'hFFFF, 16'hAB40);
        write_entry(3'd1, 1'b0, 4'h0, 16'hFFF0, 16'h1968);
        write_entry(3'd2, 1'b0, 4'h0, 16'hFFFF, 16'hAB51);
    endtask

    task automatic launch(input logic [3:0] ns, input logic [TMO_W-1:0] tl, input bit push,
                          input logic ep, input logic [2:0] ef);
        bus.num_steps = ns;
        bus.tmo_limit = tl;
        bus.start     = 1'b1;
        if (push) sb.push_back('{pass: ep, fstep: ef});
        tick();
        bus.start     = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (bus.done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_step(input logic [2:0] s, input int budget);
        int n = 0;
        while (bus.cur_step !== s && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        exp_t e;
        resetb = 1'b0;
        drive(16'h0, 4'h0);
        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
        bus.num_steps = '0; bus.tmo_limit = '0; bus.start = 1'b0;
        tick(3);
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", bus.done); end
        vectors++; if (bus.pass !== 1'b0) begin miscompares++; $display("FAIL reset_pass: got %b want 0", bus.pass); end
        vectors++; if (bus.fail_step !== 3'd0) begin miscompares++; $display("FAIL reset_fail_step: got %0d want 0", bus.fail_step); end
        vectors++; if (bus.cur_step !== 3'd0) begin miscompares++; $display("FAIL reset_cur_step: got %0d want 0", bus.cur_step); end
        resetb = 1'b1;
        tick(2);
        vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL idle_done: got %b want 0", bus.done); end
        e.pass = 1'b0;
    endtask

    task automatic test_pass_seq();
        exp_t e;
        int n;
        load_main_table();
        drive(16'hAB40, 4'h0);
        launch(4'd3, 24'd1000, 1'b1, 1'b1, 3'd0);
        tick(5);
        drive(16'h1961, 4'h0);
        tick(5);
        drive(16'hAB51, 4'h0);
        tick(5);
        wait_done(4, n);
        e = sb.pop_front();
        vectors++; if (bus.done !== 1'b1) begin miscompares++; $display("FAIL seq_done: got %b want 1", bus.done); end
        vectors++; if (bus.pass !== e.pass) begin miscompares++; $display("FAIL seq_pass: got %b want %b", bus.pass, e.pass); end
        vectors++; if (bus.cur_step !== 3'd2) begin miscompares++; $display("FAIL seq_cur_step: got %0d want 2", bus.cur_step); end
    endtask

    task automatic test_timeout();
        exp_t e;
        int n;
        drive(16'hAB40, 4'h0);
        launch(4'd3, 24'd1000, 1'b1, 1'b0, 3'd1);
        wait_step(3'd1, 20);
        vectors++; if (bus.cur_step !== 3'd1) begin miscompares++; $display("FAIL tmo_reach_step1: got %0d want 1", bus.cur_step); end
        drive(16'h0000, 4'h0);
        wait_done(1100, n);
        e = sb.pop_front();
        vectors++; if (n !== 1000) begin miscompares++; $display("FAIL tmo_cycles: got %0d want 1000", n); end
        vectors++; if (bus.done !== 1'b1) begin miscompares++; $display("FAIL tmo_done: got %b want 1", bus.done); end
        vectors++; if (bus.pass !== e.pass) begin miscompares++; $display("FAIL tmo_pass: got %b want %b", bus.pass, e.pass); end
        vectors++; if (bus.fail_step !== e.fstep) begin miscompares++; $display("FAIL tmo_fail_step: got %0d want %0d", bus.fail_step, e.fstep); end
    endtask

    task automatic test_status();
        exp_t e;
        write_entry(3'd0, 1'b1, 4'hA, 16'hFFFF, 16'hAB40);
        drive(16'hAB40, 4'h5);
        launch(4'd1, 24'd0, 1'b1, 1'b1, 3'd0);
        tick(10);
        vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL stat_wrong_busy: got %b want 1", bus.busy); end
        vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL stat_wrong_done: got %b want 0", bus.done); end
        drive(16'hAB40, 4'hA);
        tick(3);
        vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL stat_early_done: got %b want 0", bus.done); end
        tick(1);
        e = sb.pop_front();
        vectors++; if (bus.done !== 1'b1) begin miscompares++; $display("FAIL stat_done: got %b want 1", bus.done); end
        vectors++; if (bus.pass !== e.pass) begin miscompares++; $display("FAIL stat_pass: got %b want %b", bus.pass, e.pass); end
    endtask

    task automatic test_glitch();
        exp_t e;
        int n;
        load_main_table();
        drive(16'h0000, 4'h0);
        launch(4'd2, 24'd0, 1'b1, 1'b1, 3'd0);
        tick(3);
        drive(16'hAB40, 4'h0);
        tick(1);
        drive(16'h0000, 4'h0);
        tick(8);
        vectors++; if (bus.cur_step !== 3'd0) begin miscompares++; $display("FAIL glitch_cur_step: got %0d want 0", bus.cur_step); end
        vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL glitch_busy: got %b want 1", bus.busy); end
        drive(16'hAB40, 4'h0);
        wait_step(3'd1, 20);
        drive(16'h196F, 4'h0);
        wait_done(20, n);
        e = sb.pop_front();
        vectors++; if (bus.done !== 1'b1) begin miscompares++; $display("FAIL glitch_done: got %b want 1", bus.done); end
        vectors++; if (bus.pass !== e.pass) begin miscompares++; $display("FAIL glitch_pass: got %b want %b", bus.pass, e.pass); end
    endtask

    task automatic test_reset_midrun();
        exp_t e;
        int n;
        load_main_table();
        drive(16'hAB40, 4'h0);
        launch(4'd3, 24'd0, 1'b0, 1'b0, 3'd0);
        wait_step(3'd1, 20);
        drive(16'h0000, 4'h0);
        tick(3);
        #2 resetb = 1'b0;
        #1;
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %b want 0", bus.done); end
        vectors++; if (bus.cur_step !== 3'd0) begin miscompares++; $display("FAIL rst_cur_step: got %0d want 0", bus.cur_step); end
        tick(2);
        resetb = 1'b1;
        tick(3);
        vectors++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL rst_idle: got done=%b busy=%b want 0 0", bus.done, bus.busy); end
        launch(4'd3, 24'd0, 1'b1, 1'b1, 3'd0);
        vectors++; if (bus.cur_step !== 3'd0 || bus.busy !== 1'b1) begin miscompares++; $display("FAIL rst_rerun_start: got step=%0d busy=%b want 0 1", bus.cur_step, bus.busy); end
        wait_done(20, n);
        e = sb.pop_front();
        vectors++; if (bus.done !== 1'b1) begin miscompares++; $display("FAIL rst_rerun_done: got %b want 1", bus.done); end
        vectors++; if (bus.pass !== e.pass) begin miscompares++; $display("FAIL rst_rerun_pass: got %b want %b", bus.pass, e.pass); end
    endtask

    task automatic test_zero_and_busy();
        exp_t e;
        int n;
        launch(4'd0, 24'd0, 1'b1, 1'b1, 3'd0);
        e = sb.pop_front();
        vectors++; if (bus.done !== 1'b1) begin miscompares++; $display("FAIL zero_done: got %b want 1", bus.done); end
        vectors++; if (bus.pass !== e.pass) begin miscompares++; $display("FAIL zero_pass: got %b want %b", bus.pass, e.pass); end
        load_main_table();
        drive(16'hAB40, 4'h0);
        launch(4'd3, 24'd0, 1'b1, 1'b1, 3'd0);
        wait_step(3'd1, 20);
        drive(16'h0000, 4'h0);
        tick(2);
        bus.num_steps = 4'd1;
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        tick(1);
        vectors++; if (bus.cur_step !== 3'd1 || bus.busy !== 1'b1) begin miscompares++; $display("FAIL busy_start_ignored: got step=%0d busy=%b want 1 1", bus.cur_step, bus.busy); end
        drive(16'h1961, 4'h0);
        tick(5);
        drive(16'hAB51, 4'h0);
        wait_done(20, n);
        e = sb.pop_front();
        vectors++; if (bus.done !== 1'b1) begin miscompares++; $display("FAIL busy_done: got %b want 1", bus.done); end
        vectors++; if (bus.pass !== e.pass) begin miscompares++; $display("FAIL busy_pass: got %b want %b", bus.pass, e.pass); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int n;
        logic [2:0] max_step;
        for (int i = 0; i < DEPTH; i++) write_entry(3'(i), 1'b0, 4'h0, 16'h0000, 16'h0000);
        launch(4'd15, 24'd0, 1'b1, 1'b1, 3'd0);
        n = 0;
        max_step = '0;
        while (bus.done !== 1'b1 && n < 60) begin
            if (bus.cur_step > max_step) max_step = bus.cur_step;
            tick();
            n++;
        end
        e = sb.pop_front();
        vectors++; if (n !== 16) begin miscompares++; $display("FAIL clamp_cycles: got %0d want 16", n); end
        vectors++; if (max_step !== 3'd7) begin miscompares++; $display("FAIL clamp_max_step: got %0d want 7", max_step); end
        vectors++; if (bus.pass !== e.pass) begin miscompares++; $display("FAIL clamp_pass: got %b want %b", bus.pass, e.pass); end
        launch(4'd3, 24'd2, 1'b1, 1'b1, 3'd0);
        wait_done(30, n);
        e = sb.pop_front();
        vectors++; if (bus.done !== 1'b1 || bus.pass !== e.pass) begin miscompares++; $display("FAIL accept_wins: got done=%b pass=%b want 1 %b", bus.done, bus.pass, e.pass); end
        launch(4'd3, 24'd1, 1'b1, 1'b0, 3'd0);
        wait_done(30, n);
        e = sb.pop_front();
        vectors++; if (bus.done !== 1'b1 || bus.pass !== e.pass) begin miscompares++; $display("FAIL tmo1_fail: got done=%b pass=%b want 1 %b", bus.done, bus.pass, e.pass); end
        vectors++; if (bus.fail_step !== e.fstep) begin miscompares++; $display("FAIL tmo1_fail_step: got %0d want %0d", bus.fail_step, e.fstep); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_pass_seq();
        test_timeout();
        test_status();
        test_glitch();
        test_reset_midrun();
        test_zero_and_busy();
        test_back_to_back();
        vectors++; if (sb.size() !== 0) begin miscompares++; $display("FAIL scoreboard_leftover: got %0d want 0", sb.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/io_sequence_checker.md
IO_SEQUENCE_CHECKER -- requirements
Module: io_sequence_checker

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of programmable expect steps (power of two, 2..16).
REQ-002 SHALL have parameter TMO_W, default 24, width of the per-step timeout counter.
REQ-003 SHALL have parameter STABLE, default 2, consecutive matching cycles required to accept a step (1..15).
REQ-004 SHALL have one clock and an asynchronous active-low reset: clock  in  1  sole clock; resetb  in  1  async active-low reset.
REQ-005 SHALL have checkbits  in  16  asynchronous pad-side observed word (mprj_io[31:16]).
REQ-006 SHALL have status  in  4  asynchronous pad-side status nibble (mprj_io[35:32]).
REQ-007 SHALL have cfg_we  in  1  write strobe for the step table.
REQ-008 SHALL have cfg_addr  in  $clog2(DEPTH)  step index written.
REQ-009 SHALL have cfg_data  in  37  {status_en[36], status_val[35:32], mask[31:16], value[15:0]}.
REQ-010 SHALL have num_steps  in  $clog2(DEPTH)+1  steps to check, sampled at start.
REQ-011 SHALL have tmo_limit  in  TMO_W  cycles allowed per step, sampled at start; 0 disables timeout.
REQ-012 SHALL have start  in  1  single-cycle pulse launching a run.
REQ-013 SHALL have busy  out  1  run in progress.
REQ-014 SHALL have done  out  1  run finished, held until next start.
REQ-015 SHALL have pass  out  1  all steps matched; valid when done.
REQ-016 SHALL have fail_step  out  $clog2(DEPTH)  index of step that timed out; valid when done and !pass.
REQ-017 SHALL have cur_step  out  $clog2(DEPTH)  step currently awaited.

Function
REQ-018 checkbits and status SHALL pass through a 2-flop synchronizer; comparisons use synchronized values only (2-cycle input latency).
REQ-019 Step k matches when ((sync_checkbits ^ value_k) & mask_k)==0 and, if status_en_k, sync_status==status_val_k.
REQ-020 States SHALL be IDLE, RUN, PASS, FAIL; reset state IDLE.
REQ-021 IDLE->RUN on start when num_steps!=0: step index=0, stable counter=0, timeout counter=0, done=0.
REQ-022 start with num_steps==0 SHALL go directly to PASS (done=1, pass=1) next cycle.
REQ-023 In RUN, stable counter increments on match, clears on non-match; reaching STABLE accepts the step, clears both counters.
REQ-024 Accepting the last step (index num_steps-1) SHALL enter PASS the next cycle; otherwise index advances by 1.
REQ-025 Timeout counter increments each RUN cycle the step is unaccepted; reaching tmo_limit (nonzero) SHALL enter FAIL with fail_step=current index.
REQ-026 Accept and timeout in the same cycle: accept wins.
REQ-027 num_steps>DEPTH SHALL be clamped to DEPTH.
REQ-028 start while busy SHALL be ignored; start in PASS/FAIL SHALL relaunch a run.
REQ-029 cfg_we during RUN SHALL write the table; a changed entry takes effect when that step is next evaluated.
REQ-030 Outputs: busy=(state==RUN); done=(state==PASS||FAIL); pass=(state==PASS); cur_step = registered index.

Reset
REQ-031 resetb low SHALL asynchronously force IDLE, busy=0, done=0, pass=0, fail_step=0, cur_step=0, counters and synchronizer flops 0.
REQ-032 Step table SHALL reset to value=0, mask=0, status_en=0 (every step matches anything).
REQ-033 Reset mid-run SHALL abort the run with no done indication; deassertion returns to IDLE awaiting start.

Structure
REQ-034 State encoding, cfg_data field offsets and the 37-bit entry width SHALL live in shared package io_check_pkg.
REQ-035 The 2-flop synchronizer SHALL be a sub-module io_sync2 (parameterized width, async active-low reset), instantiated once for the 20 input bits.
REQ-036 Step table SHALL be a flop array, no macro RAM.

Verification
REQ-037 Table {AB40/FFFF, 1968/FFF0, AB51/FFFF}, num_steps=3, tmo_limit=1000; drive AB40, 1961, AB51 each 5 cycles -> done=1, pass=1 within STABLE+2 cycles of last value.
REQ-038 Same table; drive AB40 then hold 0000 -> FAIL after 1000 cycles of step 1, fail_step=1, pass=0.
REQ-039 Step 0 value AB40, status_en=1, status_val=A; drive checkbits AB40 with status 5 -> no accept; status A -> accept after STABLE cycles.
REQ-040 One-cycle glitch of correct value with STABLE=2 -> not accepted, cur_step unchanged.
REQ-041 Assert resetb low mid-run at step 1 -> busy=0, done=0, cur_step=0 immediately; new start reruns from step 0.
REQ-042 num_steps=0 start -> done=1, pass=1 next cycle; start while busy -> ignored, cur_step unaffected.
